core_lsu: RTL and testbench

Load/store unit between the MEM stage and the data memory port. It accepts one access per handshake from MEM, drives a req/gnt/rvalid data-memory bus with byte enables and lane-replicated write data, and returns load data that has been lane-extracted and sign- or zero-extended. It stalls the pipeline until the access completes. Misaligned accesses complete without touching memory and are flagged as errors.

---
 rtl/core_lsu.sv | 185 ++++++++++++++++++
 tb/tb_core_lsu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// Load/store unit: one MEM-stage access per handshake onto a req/gnt/rvalid data bus.
// Handles byte-lane placement of store data and lane extraction/extension of load data.
module core_lsu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,
  output logic            stall_o,
  output logic            dm_req_o,
  output logic            dm_we_o,
  output logic [XLEN-1:0] dm_addr_o,
  output logic [XLEN-1:0] dm_wdata_o,
  output logic [7:0]      dm_be_o,
  input  logic            dm_gnt_i,
  input  logic            dm_rvalid_i,
  input  logic [XLEN-1:0] dm_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [2:0]      off_q, off_d;
  logic            dm_req_q, dm_req_d;
  logic            dm_we_q, dm_we_d;
  logic [XLEN-1:0] dm_addr_q, dm_addr_d;
  logic [XLEN-1:0] dm_wdata_q, dm_wdata_d;
  logic [7:0]      dm_be_q, dm_be_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            misaligned;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rdata_shift;
  logic [XLEN-1:0] load_data;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hff;
    wdata_rep  = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        size_mask = 8'h01;
        wdata_rep = {8{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        size_mask  = 8'h03;
        wdata_rep  = {4{req_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned = |req_addr_i[1:0];
        size_mask  = 8'h0f;
        wdata_rep  = {2{req_wdata_i[31:0]}};
      end
      default: misaligned = |req_addr_i[2:0];
    endcase
  end

  // Lane-extract the addressed field, then extend it; a doubleword needs no extension.
  always_comb begin
    rdata_shift = dm_rdata_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_data = {{(XLEN-8){~uns_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_data = {{(XLEN-16){~uns_q & rdata_shift[15]}}, rdata_shift[15:0]};
      2'b10:   load_data = {{(XLEN-32){~uns_q & rdata_shift[31]}}, rdata_shift[31:0]};
      default: load_data = rdata_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_be_d     = dm_be_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          off_d  = req_addr_i[2:0];
          if (misaligned) begin
            state_d     = StDone;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d    = StReq;
            dm_req_d   = 1'b1;
            dm_we_d    = req_we_i;
            dm_addr_d  = {req_addr_i[XLEN-1:3], 3'b000};
            dm_wdata_d = wdata_rep;
            dm_be_d    = size_mask << req_addr_i[2:0];
          end
        end
      end
      StReq: begin
        if (dm_gnt_i) begin
          dm_req_d = 1'b0;
          if (dm_we_q) begin
            state_d     = StDone;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dm_rvalid_i) begin
          state_d     = StDone;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = load_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 3'b000;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      dm_be_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_be_q     <= dm_be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign stall_o     = ((state_q == StIdle) & req_valid_i) | (state_q == StReq) |
                       (state_q == StWait);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign dm_req_o    = dm_req_q;
  assign dm_we_o     = dm_we_q;
  assign dm_addr_o   = dm_addr_q;
  assign dm_wdata_o  = dm_wdata_q;
  assign dm_be_o     = dm_be_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed scenarios plus randomized accesses with
// random grant/rvalid latency, checked cycle by cycle against an arithmetic model.
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o, stall_o;
  logic [63:0] rsp_data_o;
  logic        dm_req_o, dm_we_o, dm_gnt_i, dm_rvalid_i;
  logic [63:0] dm_addr_o, dm_wdata_o, dm_rdata_i;
  logic [7:0]  dm_be_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] last_data = '0;
  logic        last_err  = 1'b0;

  core_lsu #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_size_i    (req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_err_o     (rsp_err_o),
    .stall_o       (stall_o),
    .dm_req_o      (dm_req_o),
    .dm_we_o       (dm_we_o),
    .dm_addr_o     (dm_addr_o),
    .dm_wdata_o    (dm_wdata_o),
    .dm_be_o       (dm_be_o),
    .dm_gnt_i      (dm_gnt_i),
    .dm_rvalid_i   (dm_rvalid_i),
    .dm_rdata_i    (dm_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One complete access starting in an IDLE cycle (called at a negedge).
  // gd = cycles of grant delay, rd = cycles between grant and rvalid beyond the minimum.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int gd, input int rd);
    int unsigned nbytes = 1 << size;
    int unsigned off    = int'(addr[2:0]);
    logic        mis    = (addr % 64'(nbytes)) != 0;
    logic [63:0] mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 1);
    logic [63:0] rep;
    logic [7:0]  be     = 8'(((1 << nbytes) - 1) << off);
    logic [63:0] field;
    logic [63:0] exp_load;

    case (size)
      2'd0:    rep = (wdata & 64'hff) * 64'h0101010101010101;
      2'd1:    rep = (wdata & 64'hffff) * 64'h0001000100010001;
      2'd2:    rep = (wdata & 64'hffff_ffff) * 64'h0000000100000001;
      default: rep = wdata;
    endcase
    field    = (rdata >> (8 * off)) & mask;
    exp_load = field;
    if ((!uns || size == 2'd3) && field[8*nbytes-1]) exp_load = field | ~mask;

    check("idle_ready", 64'(req_ready_o), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("idle_stall", 64'(stall_o), 64'd0);
    check("rsp_data_hold", rsp_data_o, last_data);
    check("rsp_err_hold", 64'(rsp_err_o), 64'(last_err));
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    #1;
    check("accept_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    // Scramble request inputs to prove the access was latched.
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom());
    req_size_i  = 2'($urandom());
    req_addr_i  = rnd64();
    req_wdata_i = rnd64();
    if (mis) begin
      check("mis_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("mis_rsp_err", 64'(rsp_err_o), 64'd1);
      check("mis_rsp_data", rsp_data_o, 64'd0);
      check("mis_dm_req", 64'(dm_req_o), 64'd0);
      check("mis_ready", 64'(req_ready_o), 64'd0);
      last_data = '0;
      last_err  = 1'b1;
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req_dm_req", 64'(dm_req_o), 64'd1);
        check("req_dm_we", 64'(dm_we_o), 64'(we));
        check("req_dm_addr", dm_addr_o, addr & ~64'h7);
        check("req_dm_be", 64'(dm_be_o), 64'(be));
        if (we) check("req_dm_wdata", dm_wdata_o, rep);
        check("req_stall", 64'(stall_o), 64'd1);
        check("req_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("req_ready", 64'(req_ready_o), 64'd0);
        dm_gnt_i    = (i == gd);
        dm_rvalid_i = 1'($urandom());
        dm_rdata_i  = rnd64();
        @(negedge clk);
      end
      dm_gnt_i    = 1'b0;
      dm_rvalid_i = 1'b0;
      if (!we) begin
        for (int j = 0; j <= rd; j++) begin
          check("wait_dm_req", 64'(dm_req_o), 64'd0);
          check("wait_stall", 64'(stall_o), 64'd1);
          check("wait_rsp_valid", 64'(rsp_valid_o), 64'd0);
          dm_rvalid_i = (j == rd);
          dm_rdata_i  = (j == rd) ? rdata : rnd64();
          dm_gnt_i    = 1'($urandom());
          @(negedge clk);
        end
        dm_rvalid_i = 1'b0;
        dm_gnt_i    = 1'b0;
      end
      check("done_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("done_rsp_err", 64'(rsp_err_o), 64'd0);
      check("done_rsp_data", rsp_data_o, we ? 64'd0 : exp_load);
      check("done_dm_req", 64'(dm_req_o), 64'd0);
      check("done_ready", 64'(req_ready_o), 64'd0);
      last_data = we ? 64'd0 : exp_load;
      last_err  = 1'b0;
    end
    check("done_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_rsp_data"}, rsp_data_o, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
    check({tag, "_stall"}, 64'(stall_o), 64'd0);
    check({tag, "_dm_req"}, 64'(dm_req_o), 64'd0);
    check({tag, "_dm_we"}, 64'(dm_we_o), 64'd0);
    check({tag, "_dm_addr"}, dm_addr_o, 64'd0);
    check({tag, "_dm_wdata"}, dm_wdata_o, 64'd0);
    check({tag, "_dm_be"}, 64'(dm_be_o), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    dm_gnt_i       = 1'b0;
    dm_rvalid_i    = 1'b0;
    dm_rdata_i     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Directed scenarios.
    access(1'b1, 2'd0, 1'b0, 64'h1005, 64'hab, 64'd0, 0, 0);
    access(1'b0, 2'd1, 1'b0, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
    access(1'b0, 2'd1, 1'b1, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
    access(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 64'h7fff_ffff_0000_0000, 2, 3);
    access(1'b0, 2'd3, 1'b0, 64'h3004, 64'd0, 64'd0, 0, 0);
    access(1'b0, 2'd3, 1'b1, 64'h0, 64'd0, 64'h8123_4567_89ab_cdef, 0, 0);
    access(1'b1, 2'd3, 1'b0, 64'h8, 64'h0123_4567_89ab_cdef, 64'd0, 0, 0);

    // Reset while waiting for load data; a late rvalid must be ignored.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_size_i  = 2'd3;
    req_addr_i  = 64'h40;
    @(negedge clk);
    req_valid_i = 1'b0;
    dm_gnt_i    = 1'b1;
    @(negedge clk);
    dm_gnt_i = 1'b0;
    check("wait_before_rst_stall", 64'(stall_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    dm_rvalid_i = 1'b1;
    dm_rdata_i  = 64'hdead_beef_dead_beef;
    check_reset_state("rst_wait");
    @(negedge clk);
    dm_rvalid_i = 1'b0;
    check_reset_state("late_rvalid");
    last_data = '0;
    last_err  = 1'b0;

    // Randomized accesses, roughly half misaligned where the size allows it.
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  sz   = 2'($urandom());
      logic [63:0] a    = rnd64();
      if ($urandom_range(1, 0) == 1) a = a & ~((64'd1 << sz) - 1);
      access(1'($urandom()), sz, 1'($urandom()), a, rnd64(), rnd64(),
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
